serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001: The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes; legal range is 2..16.
REQ-002: The block SHALL have derived constant W = 8*NBYTES, giving the operand and result width in bits.
REQ-003: Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004: Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005: Port start, input, 1 bit: operation request, sampled on the rising edge.
REQ-006: Port sub, input, 1 bit: operation select, 0 = A+B, 1 = A-B; sampled with start.
REQ-007: Port a, input, W bits: signed two's-complement operand A, sampled with start.
REQ-008: Port b, input, W bits: signed two's-complement operand B, sampled with start.
REQ-009: Port ready, output, 1 bit: high when start will be accepted.
REQ-010: Port done, output, 1 bit: one-cycle pulse indicating the result is valid.
REQ-011: Port sum, output, W bits: signed result.
REQ-012: Port cout, output, 1 bit: carry out of the MSB.
REQ-013: Port v, output, 1 bit: signed overflow flag.

Function
REQ-014: The block SHALL compute the W-bit result using one shared 8-bit adder slice, one byte per cycle, LSB byte first.
REQ-015: The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016: ready SHALL be 1 in IDLE and DONE, and 0 in ADD.
REQ-017: start with ready=1 SHALL perform these acceptance actions:
- latch a, and latch b if sub=0 or ~b if sub=1;
- set the byte index to 0;
- set the carry register to sub;
- go to ADD.
REQ-018: start with ready=0 SHALL be ignored without any effect on the operation in progress.
REQ-019: In ADD, each cycle SHALL write slice(a_byte[idx], b_byte[idx], carry) into sum byte idx, update carry, and increment idx.
REQ-020: When idx = NBYTES-1 in ADD, the FSM SHALL go to DONE, with cout = slice carry out and v = (slice bit-7 carry) XOR (slice bit-6 carry).
REQ-021: done SHALL be 1 only in DONE, for exactly one cycle.
REQ-022: Latency SHALL be as follows:
- start accepted at edge k;
- done high in the cycle following edge k+NBYTES;
- result available NBYTES+1 cycles after the request.
REQ-023: sum, cout and v SHALL hold their last values from DONE until the next accepted start completes.
REQ-024: Intermediate bytes SHALL be visible on sum during ADD; the result is only valid with done.
REQ-025: start in DONE SHALL be accepted (back-to-back operation): the FSM goes to ADD and done falls on the next cycle.
REQ-026: DONE with no start SHALL return to IDLE.
REQ-027: The subtract flag SHALL use the identical v rule; cout=1 on subtract means no borrow.

Reset
REQ-028: rst_n=0 SHALL asynchronously force the following state, at any time including mid-ADD:
- state IDLE, ready=1, done=0;
- sum=0, cout=0, v=0;
- idx=0, carry=0;
- latched operands cleared.
REQ-029: An operation interrupted by reset SHALL be discarded with no done pulse, and after release the block SHALL accept start on the first edge.

Structure
REQ-030: A shared package serial_add_pkg SHALL hold the FSM state encoding (IDLE, ADD, DONE) and the byte-width constant 8.
REQ-031: The 8-bit combinational adder SHALL be a separate sub-module, rca8_slice, with:
- inputs: x[7:0], y[7:0], ci;
- outputs: s[7:0], co, c6.
REQ-032: The index counter SHALL be sized clog2(NBYTES) bits.

Verification
REQ-033: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, v=1, with done exactly 5 cycles after start.
REQ-034: a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, v=0.
REQ-035: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, v=0; then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, v=1.
REQ-036: start pulsed again 2 cycles into ADD with different operands -> ignored; the first result is reported and ready=0 during ADD.
REQ-037: start asserted in DONE with a=3, b=4 -> no IDLE cycle; the second done occurs 4 cycles later with sum=0x00000007.
REQ-038: rst_n low at ADD idx=2 -> outputs zero immediately, no done pulse; a new start after release gives the correct result.

Source files
------------

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the byte-serial adder/subtractor:
//   - state_e : FSM state encoding (IDLE, ADD, DONE)
//   - BYTE_W  : width of the shared adder slice, in bits
//   - idx_width() : index-counter width for a given byte count
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes nbytes bytes; never narrower than 1 bit.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage : serial_add_pkg

// File: rtl/rca8_slice.sv
// -----------------------------------------------------------------------------
// rca8_slice
// Purely combinational 8-bit ripple-carry adder slice.
// Ports:
//   x, y : 8-bit addends
//   ci   : carry in
//   s    : 8-bit sum
//   co   : carry out of bit 7
//   c6   : carry out of bit 6 (the carry into bit 7), used for signed overflow
// -----------------------------------------------------------------------------
module rca8_slice (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       c6
);

  logic [8:0] c;

  // NOTE: every combinational output gets a value before any conditional
  // or looped logic so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign co = c[8];
  assign c6 = c[7];

endmodule : rca8_slice

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Byte-serial signed adder/subtractor. One shared 8-bit slice processes the
// operands LSB byte first, one byte per clock, under a three-state FSM.
//
// Parameters:
//   NBYTES : operand width in bytes (2..16); W = 8*NBYTES
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : operation request, accepted when ready is high
//   sub    : 0 = a+b, 1 = a-b (sampled with start)
//   a, b   : signed operands (sampled with start)
//   ready  : high in IDLE and DONE (start will be accepted)
//   done   : one-cycle pulse, result valid
//   sum    : result; intermediate bytes appear while adding
//   cout   : carry out of the MSB (on subtract, 1 = no borrow)
//   v      : signed overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     ready,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     v
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;       // holds ~b when subtracting
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  // ---------------------------------------------------------------------------
  // Byte select for the shared slice
  // ---------------------------------------------------------------------------
  logic [7:0] a_byte, b_byte, slice_s;
  logic       slice_co, slice_c6;

  always_comb begin
    a_byte = a_q[7:0];
    b_byte = b_q[7:0];
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_byte = a_q[i*BYTE_W +: BYTE_W];
        b_byte = b_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  rca8_slice u_slice (
    .x  (a_byte),
    .y  (b_byte),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c6 (slice_c6)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          idx_d   = '0;
          carry_d = sub;
          state_d = ADD;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      ADD: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*BYTE_W +: BYTE_W] = slice_s;
          end
        end
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Flags come from the top byte only; overflow is carry-in vs
          // carry-out of the sign bit, identical for add and subtract.
          cout_d  = slice_co;
          v_d     = slice_co ^ slice_c6;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the operand and result registers are plain flops (not a memory
  // array), so clearing them in the async reset is cheap and keeps a
  // discarded operation from leaking into later outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready = (state_q != ADD);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign v     = v_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (NBYTES = 4): fixed vector table,
// hand-written multi-cycle corner sequences, and random operations compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int TMO    = 4 * NBYTES + 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, cout, v;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .v     (v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain W+1-bit arithmetic; subtraction as a + (2^W - b).
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] rs, output logic rc, output logic rv);
    logic [W:0] r;
    if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else    r = {1'b0, ma} + {1'b0, mb};
    rs = r[W-1:0];
    rc = r[W];
    if (ms) rv = (ma[W-1] != mb[W-1]) && (rs[W-1] != ma[W-1]);
    else    rv = (ma[W-1] == mb[W-1]) && (rs[W-1] != ma[W-1]);
  endtask

  // Issues one operation (inputs change 1 time unit after a rising edge) and
  // waits for done. Returns the number of edges from acceptance to done.
  // glitch_at >= 0 drives a second start with other operands after that
  // many edges into the operation; it must be ignored.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                        input int glitch_at, output int lat);
    int n;
    check("ready_before_start", ready, 1);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~oa; b = oa ^ ob; sub = ~os;   // scramble inputs: operands must be latched
    n = 0;
    lat = -1;
    while (n < TMO) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      check("ready_low_in_add", ready, 0);
      if (n == glitch_at) begin
        a = 32'h0000FFFF; b = 32'h0000FFFF; sub = 1'b1; start = 1'b1;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
    start = 1'b0;
  endtask

  task automatic expect_idle_next();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("ready_in_idle", ready, 1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] es;
    logic ec, ev;

    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};

    // Reset state
    #2;
    check("rst_ready", ready, 1);
    check("rst_done",  done,  0);
    check("rst_sum",   sum,   0);
    check("rst_cout",  cout,  0);
    check("rst_v",     v,     0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table; latency is NBYTES edges after acceptance
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, -1, lat);
      check($sformatf("vec%0d_latency", i), lat, NBYTES);
      check($sformatf("vec%0d_sum", i),  sum,  vecs[i].sum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("vec%0d_v", i),    v,    vecs[i].v);
      expect_idle_next();
      check($sformatf("vec%0d_sum_hold", i), sum, vecs[i].sum);
    end

    // start during ADD is ignored
    run_op(32'h00000010, 32'h00000020, 1'b0, 2, lat);
    check("glitch_latency", lat, NBYTES);
    check("glitch_sum", sum, 32'h00000030);
    check("glitch_cout", cout, 0);
    expect_idle_next();

    // Back-to-back: start in DONE, no IDLE cycle
    run_op(32'h00000001, 32'h00000002, 1'b0, -1, lat);
    check("b2b_first_sum", sum, 32'h00000003);
    check("b2b_ready_in_done", ready, 1);
    run_op(32'h00000003, 32'h00000004, 1'b0, -1, lat);
    check("b2b_latency", lat, NBYTES);
    check("b2b_sum", sum, 32'h00000007);
    expect_idle_next();

    // Reset in the middle of ADD (idx = 2)
    a = 32'h01020304; b = 32'h10203040; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_sum",   sum,   0);
    check("midrst_cout",  cout,  0);
    check("midrst_v",     v,     0);
    check("midrst_done",  done,  0);
    check("midrst_ready", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // A stale done would arrive before NBYTES edges and shorten the latency.
    run_op(32'h01020304, 32'h10203040, 1'b0, -1, lat);
    check("postrst_latency", lat, NBYTES);
    check("postrst_sum", sum, 32'h11223344);
    expect_idle_next();

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
      if (i % 8 == 1) rb = {1'b1, {(W-1){1'b0}}};
      model(ra, rb, rs, es, ec, ev);
      run_op(ra, rb, rs, -1, lat);
      check("rand_latency", lat, NBYTES);
      check("rand_sum", sum, es);
      check("rand_cout", cout, ec);
      check("rand_v", v, ev);
      if (i % 2 == 0) expect_idle_next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_add_ctrl
